// File: rtl/uart_reply_framer_pkg.sv
// Shared types and constants for the UART reply framer (package uart_reply_pkg).
package uart_reply_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_e;

  localparam logic [1:0]  HDR_PAD    = 2'b00;
  localparam int unsigned UART_NBITS = 8;

  function automatic int unsigned calc_nb(input int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_reply_framer_if.sv
// Request/response bundle between the control FSM (master) and the reply framer (slave).
interface uart_reply_framer_if #(
  parameter int unsigned DataWidth = 12
);
  logic                 send_i;
  logic [1:0]           opcode_i;
  logic [DataWidth-1:0] data_i;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (output send_i, opcode_i, data_i, input tx_o, busy_o, done_o);
  modport slave  (input send_i, opcode_i, data_i, output tx_o, busy_o, done_o);
endinterface

// File: rtl/uart_reply_framer_byte_tx.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit; each bit lasts Sticks ticks.
module uart_byte_tx
  import uart_reply_pkg::*;
#(
  parameter int unsigned Sticks = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  start_i,
  input  logic [UART_NBITS-1:0] din_i,
  output logic                  tx_o,
  output logic                  eob_o
);
  localparam int unsigned TCW = (Sticks > 1) ? $clog2(Sticks) : 1;
  localparam int unsigned FW  = UART_NBITS + 2;
  localparam int unsigned BCW = $clog2(FW);

  logic           busy_q;
  logic [FW-1:0]  sh_q, sh_cur;
  logic [TCW-1:0] tc_q, tc_cur;
  logic [BCW-1:0] bc_q, bc_cur;
  logic           active, bit_end;

  // The start cycle already counts as the first cycle of the start bit, so the
  // line drops with start_i and the first tick is not lost.
  always_comb begin
    active  = busy_q | start_i;
    sh_cur  = start_i ? {1'b1, din_i, 1'b0} : sh_q;
    tc_cur  = start_i ? '0 : tc_q;
    bc_cur  = start_i ? '0 : bc_q;
    bit_end = active && tick_i && (tc_cur == TCW'(Sticks - 1));
    eob_o   = bit_end && (bc_cur == BCW'(FW - 1));
    tx_o    = busy_q ? sh_q[0] : ~start_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      sh_q   <= '1;
      tc_q   <= '0;
      bc_q   <= '0;
    end else if (active) begin
      busy_q <= ~eob_o;
      if (bit_end) begin
        tc_q <= '0;
        bc_q <= bc_cur + BCW'(1);
        sh_q <= {1'b1, sh_cur[FW-1:1]};
      end else begin
        tc_q <= tick_i ? tc_cur + TCW'(1) : tc_cur;
        bc_q <= bc_cur;
        sh_q <= sh_cur;
      end
    end
  end

endmodule

// File: rtl/uart_reply_framer.sv
// Reply framer: sends {header, payload MSB byte first[, checksum]} over UART.
// Optional checksum byte enabled by macro REPLY_CHECKSUM_EN.
module uart_reply_framer
  import uart_reply_pkg::*;
#(
  parameter int unsigned DataWidth  = 12,
  parameter int unsigned Sticks     = 16,
  parameter logic [3:0]  SyncNibble = 4'hA
) (
  input logic                 clk_i,
  input logic                 rst_i,
  input logic                 tick_i,
  uart_reply_framer_if.slave  bus
);
  localparam int unsigned NB = calc_nb(DataWidth);
`ifdef REPLY_CHECKSUM_EN
  localparam int unsigned NT = NB + 2;
`else
  localparam int unsigned NT = NB + 1;
`endif
  localparam int unsigned IDXW = $clog2(NT);
  localparam int unsigned PW   = NB * UART_NBITS;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q;
  logic [1:0]            op_q;
  logic [PW-1:0]         data_q;
  logic                  accept, ser_start, ser_eob, last_byte;
  logic [UART_NBITS-1:0] hdr_byte, cur_byte;

  // DONE accepts too, so a request held through done_o chains frames without an idle bit.
  assign accept    = bus.send_i && ((state_q == IDLE) || (state_q == DONE));
  assign last_byte = (idx_q == IDXW'(NT - 1));
  assign hdr_byte  = {SyncNibble, HDR_PAD, op_q};

  always_comb begin
    state_d   = state_q;
    ser_start = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD: begin
        ser_start = 1'b1;
        state_d   = SEND;
      end
      SEND:    if (ser_eob) state_d = last_byte ? DONE : LOAD;
      DONE:    state_d = accept ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_byte = hdr_byte;
    for (int unsigned j = 0; j < NB; j++) begin
      if (idx_q == IDXW'(j + 1)) cur_byte = data_q[(NB-1-j)*UART_NBITS +: UART_NBITS];
    end
`ifdef REPLY_CHECKSUM_EN
    if (last_byte) begin
      cur_byte = hdr_byte;
      for (int unsigned j = 0; j < NB; j++) begin
        cur_byte = cur_byte ^ data_q[j*UART_NBITS +: UART_NBITS];
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.opcode_i;
        data_q <= PW'(bus.data_i);
      end
      if ((state_q == SEND) && ser_eob && !last_byte) idx_q <= idx_q + IDXW'(1);
      else if (state_q == DONE)                       idx_q <= '0;
    end
  end

  assign bus.busy_o = (state_q == LOAD) || (state_q == SEND);
  assign bus.done_o = (state_q == DONE);

  uart_byte_tx #(
    .Sticks(Sticks)
  ) u_byte_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_i (tick_i),
    .start_i(ser_start),
    .din_i  (cur_byte),
    .tx_o   (bus.tx_o),
    .eob_o  (ser_eob)
  );

endmodule

// File: tb/tb_uart_reply_framer.sv
// Scoreboard bench for uart_reply_framer: a tick-counting UART monitor decodes the line
// and pops hand-computed expected bytes; directed scenarios drive the requests.
module tb_uart_reply_framer;
  localparam int unsigned DW = 12;
  localparam int unsigned BIT_CYC_SPARSE = 16 * 54;
`ifdef REPLY_CHECKSUM_EN
  localparam int unsigned DONE_LAT = 641;
`else
  localparam int unsigned DONE_LAT = 481;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic tick_i = 1'b0;
  int unsigned tick_period = 1;
  int unsigned tick_cnt = 0;

  uart_reply_framer_if #(.DataWidth(DW)) bus ();

  uart_reply_framer #(
    .DataWidth (DW),
    .Sticks    (16),
    .SyncNibble(4'hA)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .tick_i(tick_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_period <= 1) tick_i = 1'b1;
      else begin
        tick_cnt = (tick_cnt + 1) % tick_period;
        tick_i   = (tick_cnt == 0);
      end
    end
  end

  // Reference receiver: counts ticks from the start cycle, samples each bit mid-way.
  logic [9:0]  mon_sh;
  int unsigned mon_n, mon_target;
  bit          mon_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i && bus.tx_o == 1'b0) begin
        mon_n     = tick_i ? 1 : 0;
        mon_abort = 1'b0;
        for (int b = 0; b < 10 && !mon_abort; b++) begin
          mon_target = 16 * b + 8;
          while (mon_n < mon_target) begin
            @(negedge clk);
            if (!rst_i) begin
              mon_abort = 1'b1;
              break;
            end
            if (tick_i) mon_n++;
          end
          if (!mon_abort) mon_sh[b] = bus.tx_o;
        end
        if (!mon_abort) begin
          check("start_bit", 32'(mon_sh[0]), 32'd0);
          check("stop_bit", 32'(mon_sh[9]), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", mon_sh[8:1]);
          end else begin
            check("line_byte", 32'(mon_sh[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] hdr, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] csum);
    exp_q.push_back(hdr);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(csum);
`else
    if (csum === 8'hxx) exp_q.push_back(csum);
`endif
  endtask

  // Drives one request cycle; returns #1 after the accepting edge.
  task automatic send_frame(input logic [1:0] op, input logic [11:0] data);
    @(posedge clk);
    #1;
    bus.send_i   = 1'b1;
    bus.opcode_i = op;
    bus.data_i   = data;
    @(posedge clk);
    #1;
    bus.send_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned start, input int unsigned limit,
                           output int unsigned cyc);
    bit ok;
    cyc = start;
    ok  = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: done_o not seen, got none after %0d cycles, expected a pulse", name, cyc);
    end
  endtask

  int unsigned cyc, ref_cyc, edges, misal;
  logic        prev_tx;
  bit          have_ref;

  initial begin
    bus.send_i   = 1'b0;
    bus.opcode_i = '0;
    bus.data_i   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(bus.tx_o), 32'd1);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b1;
    repeat (5) @(posedge clk);

    // Basic frame, tick tied high.
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    @(negedge clk);
    check("basic_tx_low_after_accept", 32'(bus.tx_o), 32'd0);
    check("basic_busy", 32'(bus.busy_o), 32'd1);
    wait_done("basic_done", 1, 2000, cyc);
    check("basic_done_latency", cyc, DONE_LAT);
    check("basic_busy_in_done", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check("basic_done_single", 32'(bus.done_o), 32'd0);
    repeat (40) @(negedge clk);
    check("basic_queue_empty", exp_q.size(), 0);

    // Request while busy must be ignored.
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    @(negedge clk);
    repeat (299) @(negedge clk);
    bus.send_i   = 1'b1;
    bus.opcode_i = 2'b11;
    bus.data_i   = 12'h123;
    @(negedge clk);
    bus.send_i = 1'b0;
    wait_done("ignore_done", 301, 2000, cyc);
    check("ignore_done_latency", cyc, DONE_LAT);
    repeat (60) @(negedge clk);
    check("ignore_no_second_frame", 32'(bus.busy_o), 32'd0);
    check("ignore_queue_empty", exp_q.size(), 0);

    // Back-to-back: request held through the done_o cycle.
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    @(negedge clk);
    repeat (99) @(negedge clk);
    bus.send_i   = 1'b1;
    bus.opcode_i = 2'b10;
    bus.data_i   = 12'h000;
    push_frame(8'hA2, 8'h00, 8'h00, 8'hA2);
    wait_done("b2b_first_done", 100, 2000, cyc);
    check("b2b_first_latency", cyc, DONE_LAT);
    @(posedge clk);
    #1;
    bus.send_i = 1'b0;
    @(negedge clk);
    check("b2b_busy_next", 32'(bus.busy_o), 32'd1);
    check("b2b_tx_start_next", 32'(bus.tx_o), 32'd0);
    wait_done("b2b_second_done", 1, 2000, cyc);
    check("b2b_second_latency", cyc, DONE_LAT);
    repeat (40) @(negedge clk);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Sparse tick: every line transition after the first lies on a 16*54-cycle grid.
    tick_period = 54;
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    @(negedge clk);
    cyc      = 1;
    prev_tx  = bus.tx_o;
    have_ref = 1'b0;
    edges    = 0;
    misal    = 0;
    ref_cyc  = 0;
    while (cyc < 60000 && !bus.done_o) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_o !== prev_tx) begin
        if (!have_ref) begin
          have_ref = 1'b1;
          ref_cyc  = cyc;
        end else begin
          edges++;
          if ((cyc - ref_cyc) % BIT_CYC_SPARSE != 0) misal++;
        end
        prev_tx = bus.tx_o;
      end
    end
    check("sparse_done_seen", 32'(bus.done_o), 32'd1);
    check("sparse_edges_seen", 32'(edges != 0), 32'd1);
    check("sparse_misaligned_edges", misal, 0);
    repeat (20) @(negedge clk);
    check("sparse_queue_empty", exp_q.size(), 0);
    tick_period = 1;

    // Reset in the middle of byte 2 aborts; a fresh frame afterwards is complete.
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    repeat (360) @(negedge clk);
    check("midreset_busy_before", 32'(bus.busy_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("midreset_tx_async", 32'(bus.tx_o), 32'd1);
    check("midreset_busy_async", 32'(bus.busy_o), 32'd0);
    check("midreset_bytes_before_abort", exp_q.size(), DONE_LAT == 641 ? 2 : 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk);
    push_frame(8'hA1, 8'h0A, 8'hBC, 8'h17);
    send_frame(2'b01, 12'hABC);
    @(negedge clk);
    wait_done("midreset_new_done", 1, 2000, cyc);
    check("midreset_new_latency", cyc, DONE_LAT);
    repeat (40) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
